npc_regstate_keymux: RTL and testbench

- Storage-and-select block for the single-cycle NPC datapath.
- Bundles three independent sub-functions behind one port list:
  - a program-counter register with a parameterised reset value;
  - a 2-port general-purpose register file (one synchronous write, one combinational read);
  - a generic keyed lookup multiplexer with a default output.
- The datapath uses the keyed mux for immediate, operand, write-enable and next-PC selection. It uses the register file as x0–x31 and the PC register as the architectural PC.

---
 rtl/npc_regstate_keymux.sv | 67 ++++++
 tb/tb_npc_regstate_keymux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/npc_regstate_keymux.sv
// NPC storage and select: architectural PC register, x0-x31 register file
// (sync write / comb read) and a keyed lookup mux with a default output.
module npc_regstate_keymux #(
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = 32'h8000_0000,
  parameter int                    NR_KEY       = 8,
  parameter int                    KEY_LEN      = 7,
  parameter int                    MUX_DATA_LEN = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH-1:0]                    pc_din,
  input  logic                                     pc_wen,
  output logic [DATA_WIDTH-1:0]                    pc_dout,
  input  logic [ADDR_WIDTH-1:0]                    rf_waddr,
  input  logic [DATA_WIDTH-1:0]                    rf_wdata,
  input  logic                                     rf_wen,
  input  logic [ADDR_WIDTH-1:0]                    rf_raddr,
  output logic [DATA_WIDTH-1:0]                    rf_rdata,
  input  logic [KEY_LEN-1:0]                       mux_key,
  input  logic [MUX_DATA_LEN-1:0]                  mux_default,
  input  logic [NR_KEY*(KEY_LEN+MUX_DATA_LEN)-1:0] mux_lut,
  output logic [MUX_DATA_LEN-1:0]                  mux_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int W     = KEY_LEN + MUX_DATA_LEN;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst)        r_pc <= PC_RESET;
    else if (pc_wen) r_pc <= pc_din;
  end

  assign pc_dout = r_pc;

  // x0 is never written, so its cell stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (rf_wen && (rf_waddr != '0)) begin
      r_rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata = (rf_raddr == '0) ? '0 : r_rf[rf_raddr];

  logic [NR_KEY-1:0][KEY_LEN-1:0]      w_key;
  logic [NR_KEY-1:0][MUX_DATA_LEN-1:0] w_data;

  for (genvar g = 0; g < NR_KEY; g++) begin : g_ent
    assign w_key[g]  = mux_lut[g*W+MUX_DATA_LEN +: KEY_LEN];
    assign w_data[g] = mux_lut[g*W +: MUX_DATA_LEN];
  end

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    mux_out = mux_default;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_key[i] == mux_key) mux_out = w_data[i];
    end
  end

endmodule

// File: tb/tb_npc_regstate_keymux.sv
// Directed bench for npc_regstate_keymux: PC/regfile sequences plus a mux vector table.
module tb_npc_regstate_keymux;

  localparam int NK  = 5;
  localparam int KL  = 7;
  localparam int DL  = 32;
  localparam int LW  = NK * (KL + DL);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_din;
  logic          pc_wen;
  logic [31:0]   pc_dout;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_wen;
  logic [4:0]    rf_raddr;
  logic [31:0]   rf_rdata;
  logic [KL-1:0] mux_key;
  logic [DL-1:0] mux_default;
  logic [LW-1:0] mux_lut;
  logic [DL-1:0] mux_out;

  int checks   = 0;
  int failures = 0;

  npc_regstate_keymux #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .PC_RESET(32'h8000_0000),
    .NR_KEY(NK), .KEY_LEN(KL), .MUX_DATA_LEN(DL)
  ) dut (
    .clk(clk), .rst(rst),
    .pc_din(pc_din), .pc_wen(pc_wen), .pc_dout(pc_dout),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mux_key(mux_key), .mux_default(mux_default), .mux_lut(mux_lut),
    .mux_out(mux_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [LW-1:0] lut;
    logic [KL-1:0] key;
    logic [DL-1:0] dflt;
    logic [DL-1:0] exp;
  } mux_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    rf_raddr = a;
    #1;
    chk(nm, rf_rdata, exp);
  endtask

  mux_vec_t vecs[$];
  logic [LW-1:0] lut_a, lut_dup;

  initial begin
    // Leftmost entry in each concatenation is index NK-1.
    lut_a   = {7'h13, 32'h1, 7'h17, 32'h2, 7'h37, 32'h3, 7'h6F, 32'h4, 7'h67, 32'h5};
    lut_dup = {7'h01, 32'hE, 7'h33, 32'hB, 7'h02, 32'hC, 7'h33, 32'hA, 7'h03, 32'hD};
    vecs.push_back('{"mux_hit_37",   lut_a,   7'h37, 32'hCAFE, 32'h3});
    vecs.push_back('{"mux_hit_67",   lut_a,   7'h67, 32'hCAFE, 32'h5});
    vecs.push_back('{"mux_hit_13",   lut_a,   7'h13, 32'hCAFE, 32'h1});
    vecs.push_back('{"mux_miss_73",  lut_a,   7'h73, 32'hCAFE, 32'hCAFE});
    vecs.push_back('{"mux_dup_33",   lut_dup, 7'h33, 32'h0,    32'hB});
    vecs.push_back('{"mux_dup_idx0", lut_dup, 7'h03, 32'h0,    32'hD});
    vecs.push_back('{"mux_dup_miss", lut_dup, 7'h7F, 32'h1234_5678, 32'h1234_5678});

    rst = 1'b0; pc_wen = 1'b1; pc_din = 32'h1234;
    rf_wen = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'hFFFF_FFFF; rf_raddr = 5'd0;
    mux_key = '0; mux_default = '0; mux_lut = '0;

    // Reset beats both enables.
    tick(); tick();
    chk("reset_pc", pc_dout, 32'h8000_0000);
    for (int a = 0; a < 32; a++) rd(a[4:0], 32'h0, $sformatf("reset_rf_x%0d", a));

    rst = 1'b1; rf_wen = 1'b0; pc_din = 32'h8000_0004;
    tick();
    chk("pc_load_after_reset", pc_dout, 32'h8000_0004);

    pc_wen = 1'b0; pc_din = 32'hDEAD_BEEF;
    tick();
    chk("pc_hold", pc_dout, 32'h8000_0004);
    pc_wen = 1'b1;
    tick();
    chk("pc_load", pc_dout, 32'hDEAD_BEEF);
    pc_wen = 1'b0;

    rf_wen = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hA5A5_0001;
    tick();
    rf_waddr = 5'd31; rf_wdata = 32'h3131_3131;
    tick();
    rf_waddr = 5'd0; rf_wdata = 32'hFFFF_FFFF;
    tick();
    rf_wen = 1'b0;
    rd(5'd5,  32'hA5A5_0001, "rf_x5");
    rd(5'd31, 32'h3131_3131, "rf_x31");
    rd(5'd0,  32'h0,         "rf_x0_ignored");

    rf_waddr = 5'd5; rf_wdata = 32'h1234_5678;
    tick();
    rd(5'd5, 32'hA5A5_0001, "rf_x5_no_wen");

    rf_wen = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'h11;
    tick();
    rf_wdata = 32'h22;
    rd(5'd7, 32'h11, "rdw_before_edge");
    tick();
    chk("rdw_after_edge", rf_rdata, 32'h22);
    rf_wen = 1'b0;

    foreach (vecs[i]) begin
      mux_lut = vecs[i].lut; mux_key = vecs[i].key; mux_default = vecs[i].dflt;
      #1;
      chk(vecs[i].name, mux_out, vecs[i].exp);
    end

    // Mid-run reset clears state already written and ignores pending loads.
    rst = 1'b0; pc_wen = 1'b1; pc_din = 32'h5555_AAAA;
    rf_wen = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'h99;
    tick();
    chk("rereset_pc", pc_dout, 32'h8000_0000);
    rd(5'd5, 32'h0, "rereset_x5");
    rd(5'd9, 32'h0, "rereset_x9");
    chk("mux_during_reset", mux_out, vecs[vecs.size()-1].exp);
    rst = 1'b1; pc_wen = 1'b0; rf_wen = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
